sad_tree_acc: RTL and testbench
===============================

Name: sad_tree_acc

Overview:
Streaming, pipelined sum-of-absolute-differences accumulator for the disparity engine. It is the successor to the power-of-two adder tree and differs from it as follows:
- accepts any node count, not only powers of two;
- computes |left−right| per node internally;
- sums one window row per accepted beat;
- accumulates ROWS consecutive beats into one block SAD;
- uses a valid/ready handshake with full-pipeline backpressure.

Parameters:
NODE_NUM, 9, pixels per window row (any integer ≥1, power of two not required)
PIX_WIDTH, 8, unsigned pixel width
ROWS, 9, beats (window rows) accumulated per block result (≥1)
LEVELS (localparam), $clog2(NODE_NUM), adder-tree stages (0 when NODE_NUM=1)
ROW_WIDTH (localparam), PIX_WIDTH+LEVELS, row-sum width
SAD_WIDTH (localparam), ROW_WIDTH+$clog2(ROWS), block-sum width; exact, overflow impossible

Ports:
clk  in  1  sole clock
rst  in  1  reset; one clock; reset is asynchronous and active-high
in_valid  in  1  input beat valid
in_ready  out  1  block can accept a beat
in_first  in  1  beat is row 0 of a new block; restarts row count
in_mask  in  NODE_NUM  per-node enable; masked node contributes 0
pix_l  in  NODE_NUM x PIX_WIDTH  left-image pixels (unpacked array)
pix_r  in  NODE_NUM x PIX_WIDTH  right-image pixels (unpacked array)
out_valid  out  1  block SAD valid
out_ready  in  1  downstream accepts
out_sad  out  SAD_WIDTH  block SAD
(SAD_TREE_MIN_EN only) best_sad  out  SAD_WIDTH; best_idx  out  16

Behaviour:
- Reset values: out_valid=0, out_sad=0, row counter=0, accumulator=0, all stage valids=0. in_ready=1 after reset.
- Stall rule:
  - adv = ~out_valid | out_ready; in_ready = adv.
  - Every pipeline register, including valids, advances only when adv=1; otherwise it holds.
  - out_sad holds while out_valid=1 and out_ready=0.
  - A beat is accepted when in_valid & in_ready.
- Stage 0 (registered):
  - d[i] = in_mask[i] ? |pix_l[i]−pix_r[i]| : 0, PIX_WIDTH bits, unsigned.
  - in_first and a stage-valid bit travel with the data through the pipeline.
- Stages 1..LEVELS: pairwise registered adders, each level one bit wider. With an odd operand count, the last operand is zero-extended and registered through unpaired.
- Accumulator stage, acting on the row sum carried with a valid beat:
  - in_first=1 resets row index k to 0 and discards any partial accumulation.
  - When k < ROWS−1: acc = (first ? 0 : acc) + row; k increments.
  - When k = ROWS−1: out_sad = (first ? 0 : acc) + row; out_valid = 1; acc = 0; k = 0.
  - ROWS=1: every beat produces a result.
- Output handshake: out_valid clears on out_valid & out_ready unless a new result loads in the same cycle, in which case out_valid stays 1.
- Latency: 2+LEVELS cycles from acceptance of the final row to out_valid (6 at defaults). Throughput is one beat per cycle with no bubbles while out_ready=1.
- in_first is ignored on a cycle with no accepted beat.
- Async reset mid-block discards all in-flight beats and partial sums.
- in_first is not required on the very first beat after reset, since k=0 already.

Optional Feature:
SAD_TREE_MIN_EN:
- Defined: adds best_sad/best_idx.
  - On each emitted result, idx increments from 0. The block index resets whenever an in_first beat starts a block after a completed one, and on rst.
  - The first result after reset loads best_sad/best_idx unconditionally.
  - Later results load only if strictly less than best_sad, so ties keep the earlier index.
  - Update happens in the cycle out_valid rises.
  - Reset values: best_sad = all-ones, best_idx = 0.
- Undefined: the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package sad_pkg: the LEVELS/ROW_WIDTH/SAD_WIDTH width-function helpers and the best_idx width constant (16).
- Sub-module sad_tree_level: one registered reduction level (N inputs → ceil(N/2) outputs, odd pass-through, stall enable). It is instantiated LEVELS times via a generate loop.

Test Plan:
- Defaults; all pixels pix_l=10, pix_r=7, mask all 1; 9 consecutive beats, first beat in_first=1, out_ready=1 → single out_valid pulse with out_sad=243, 6 cycles after the 9th beat is accepted.
- pix_l=0, pix_r=255, all masks 1, 9 rows → out_sad=20655, no wrap; then mask only node 4 → out_sad=2295.
- NODE_NUM=5, ROWS=1; d={1,2,3,4,5} → out_sad=15 each beat, latency 5, one result per cycle streaming.
- out_ready held 0 for 10 cycles while in_valid=1 → in_ready=0 while out_valid=1; out_sad stable; no beat lost or duplicated after release.
- 4 rows of a block, then in_first=1 restarting with 9 rows of value 1 → out_sad=81, i.e. partial sum discarded; rst asserted mid-block → outputs 0 immediately.
- SAD_TREE_MIN_EN: block SADs 50,30,30,40 → best_sad=30, best_idx=1.

Source files
------------

// File: rtl/sad_pkg.sv
// Width helpers shared by the SAD accumulator and its adder-tree levels.
package sad_pkg;

  localparam int BEST_IDX_W = 16;

  function automatic int sad_levels(input int n);
    return (n <= 1) ? 0 : $clog2(n);
  endfunction

  function automatic int sad_row_width(input int pix_w, input int n);
    return pix_w + sad_levels(n);
  endfunction

  function automatic int sad_sum_width(input int pix_w, input int n, input int rows);
    return sad_row_width(pix_w, n) + ((rows <= 1) ? 0 : $clog2(rows));
  endfunction

  // Operand count entering tree level lvl (each level halves, rounding up).
  function automatic int sad_level_nodes(input int n, input int lvl);
    int c;
    c = n;
    for (int i = 0; i < lvl; i++) c = (c + 1) / 2;
    return c;
  endfunction

endpackage

// File: rtl/sad_tree_level.sv
// One registered reduction level: N_IN operands -> ceil(N_IN/2) sums, one bit wider.
module sad_tree_level
  import sad_pkg::*;
#(
  parameter int N_IN = 2,
  parameter int W_IN = 8,
  localparam int N_OUT = (N_IN + 1) / 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_en,
  input  logic            i_valid,
  input  logic            i_first,
  input  logic [W_IN-1:0] i_data [N_IN],
  output logic            o_valid,
  output logic            o_first,
  output logic [W_IN:0]   o_data [N_OUT]
);

  logic [W_IN:0] w_sum [N_OUT];

  // An odd last operand has no partner and is carried through zero-extended.
  for (genvar j = 0; j < N_OUT; j++) begin : g_node
    if (2 * j + 1 < N_IN) begin : g_pair
      assign w_sum[j] = {1'b0, i_data[2*j]} + {1'b0, i_data[2*j+1]};
    end else begin : g_pass
      assign w_sum[j] = {1'b0, i_data[2*j]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_valid <= 1'b0;
      o_first <= 1'b0;
      for (int j = 0; j < N_OUT; j++) o_data[j] <= '0;
    end else if (i_en) begin
      o_valid <= i_valid;
      o_first <= i_first;
      for (int j = 0; j < N_OUT; j++) o_data[j] <= w_sum[j];
    end
  end

endmodule

// File: rtl/sad_tree_acc.sv
// Pipelined block SAD: per-node |l-r|, adder tree per row, ROWS-row accumulation.
// Optional running minimum (best_sad/best_idx) when SAD_TREE_MIN_EN is defined.
module sad_tree_acc
  import sad_pkg::*;
#(
  parameter int NODE_NUM  = 9,
  parameter int PIX_WIDTH = 8,
  parameter int ROWS      = 9,
  localparam int LEVELS    = sad_levels(NODE_NUM),
  localparam int ROW_WIDTH = sad_row_width(PIX_WIDTH, NODE_NUM),
  localparam int SAD_WIDTH = sad_sum_width(PIX_WIDTH, NODE_NUM, ROWS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_first,
  input  logic [NODE_NUM-1:0]  in_mask,
  input  logic [PIX_WIDTH-1:0] pix_l [NODE_NUM],
  input  logic [PIX_WIDTH-1:0] pix_r [NODE_NUM],
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [SAD_WIDTH-1:0] out_sad
`ifdef SAD_TREE_MIN_EN
  ,
  output logic [SAD_WIDTH-1:0]  best_sad,
  output logic [BEST_IDX_W-1:0] best_idx
`endif
);

  localparam int K_W = (ROWS > 1) ? $clog2(ROWS) : 1;

  // valid/ready: a beat moves when valid & ready; the whole pipe advances only
  // when the output register is empty or being drained (w_adv), else holds.
  logic w_adv;
  assign w_adv    = ~out_valid | out_ready;
  assign in_ready = w_adv;

  logic [PIX_WIDTH-1:0] r_d [NODE_NUM];
  logic                 r_v0;
  logic                 r_f0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v0 <= 1'b0;
      r_f0 <= 1'b0;
      for (int i = 0; i < NODE_NUM; i++) r_d[i] <= '0;
    end else if (w_adv) begin
      r_v0 <= in_valid;
      r_f0 <= in_valid & in_first;
      for (int i = 0; i < NODE_NUM; i++)
        r_d[i] <= !in_mask[i]           ? '0 :
                  (pix_l[i] > pix_r[i]) ? pix_l[i] - pix_r[i] : pix_r[i] - pix_l[i];
    end
  end

  for (genvar l = 0; l < LEVELS; l++) begin : g_lvl
    localparam int NI = sad_level_nodes(NODE_NUM, l);
    localparam int NO = sad_level_nodes(NODE_NUM, l + 1);
    localparam int WI = PIX_WIDTH + l;
    logic [WI-1:0] w_in  [NI];
    logic [WI:0]   w_out [NO];
    logic          w_vi, w_fi, w_vo, w_fo;
    if (l == 0) begin : g_src_stage0
      for (genvar j = 0; j < NI; j++) begin : g_cp
        assign w_in[j] = r_d[j];
      end
      assign w_vi = r_v0;
      assign w_fi = r_f0;
    end else begin : g_src_level
      for (genvar j = 0; j < NI; j++) begin : g_cp
        assign w_in[j] = g_lvl[l-1].w_out[j];
      end
      assign w_vi = g_lvl[l-1].w_vo;
      assign w_fi = g_lvl[l-1].w_fo;
    end
    sad_tree_level #(.N_IN(NI), .W_IN(WI)) u_level (
      .clk     (clk),
      .rst     (rst),
      .i_en    (w_adv),
      .i_valid (w_vi),
      .i_first (w_fi),
      .i_data  (w_in),
      .o_valid (w_vo),
      .o_first (w_fo),
      .o_data  (w_out)
    );
  end

  logic [ROW_WIDTH-1:0] w_row;
  logic                 w_row_v;
  logic                 w_row_f;
  if (LEVELS == 0) begin : g_row_direct
    assign w_row   = r_d[0];
    assign w_row_v = r_v0;
    assign w_row_f = r_f0;
  end else begin : g_row_tree
    assign w_row   = g_lvl[LEVELS-1].w_out[0];
    assign w_row_v = g_lvl[LEVELS-1].w_vo;
    assign w_row_f = g_lvl[LEVELS-1].w_fo;
  end

  logic [K_W-1:0]       r_k;
  logic [SAD_WIDTH-1:0] r_acc;
  logic [K_W-1:0]       w_k_eff;
  logic [SAD_WIDTH-1:0] w_sum;
  logic                 w_last;

  // A first-row beat restarts the block, dropping any partial accumulation.
  always_comb begin
    w_k_eff = w_row_f ? '0 : r_k;
    w_sum   = (w_row_f ? '0 : r_acc) + SAD_WIDTH'(w_row);
    w_last  = (w_k_eff == K_W'(ROWS - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_k       <= '0;
      r_acc     <= '0;
      out_valid <= 1'b0;
      out_sad   <= '0;
    end else if (w_adv) begin
      out_valid <= w_row_v & w_last;
      if (w_row_v) begin
        if (w_last) begin
          out_sad <= w_sum;
          r_acc   <= '0;
          r_k     <= '0;
        end else begin
          r_acc <= w_sum;
          r_k   <= w_k_eff + 1'b1;
        end
      end
    end
  end

`ifdef SAD_TREE_MIN_EN
  logic                  r_have_best;
  logic [BEST_IDX_W-1:0] r_idx;
  logic                  w_restart;
  logic [BEST_IDX_W-1:0] w_idx_cur;

  // A first-row beat landing on a block boundary starts a new index sequence.
  assign w_restart = w_row_v & w_row_f & (r_k == '0);
  assign w_idx_cur = w_restart ? '0 : r_idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_have_best <= 1'b0;
      r_idx       <= '0;
      best_sad    <= '1;
      best_idx    <= '0;
    end else if (w_adv && w_row_v) begin
      if (w_last) begin
        r_idx <= w_idx_cur + 1'b1;
        if (!r_have_best || (w_sum < best_sad)) begin
          r_have_best <= 1'b1;
          best_sad    <= w_sum;
          best_idx    <= w_idx_cur;
        end
      end else if (w_restart) begin
        r_idx <= '0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_sad_tree_acc.sv
// Randomized bench for sad_tree_acc: default instance against a block-sum model,
// plus a NODE_NUM=5 / ROWS=1 streaming instance.
module tb_sad_tree_acc;
  import sad_pkg::*;

  localparam int N   = 9;
  localparam int PW  = 8;
  localparam int R   = 9;
  localparam int SW  = sad_sum_width(PW, N, R);
  localparam int N2  = 5;
  localparam int SW2 = sad_sum_width(PW, N2, 1);
  localparam int LAT = 2 + sad_levels(N);
  localparam int LAT2 = 2 + sad_levels(N2);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic          in_valid = 1'b0, in_first = 1'b0, out_ready = 1'b1;
  logic          in_ready, out_valid;
  logic [N-1:0]  in_mask = '0;
  logic [PW-1:0] pix_l [N];
  logic [PW-1:0] pix_r [N];
  logic [SW-1:0] out_sad;

  logic          in_valid2 = 1'b0, in_first2 = 1'b0;
  logic          in_ready2, out_valid2;
  logic [N2-1:0] in_mask2 = '1;
  logic [PW-1:0] pix_l2 [N2];
  logic [PW-1:0] pix_r2 [N2];
  logic [SW2-1:0] out_sad2;

`ifdef SAD_TREE_MIN_EN
  logic [SW-1:0]         best_sad;
  logic [BEST_IDX_W-1:0] best_idx;
  logic [SW2-1:0]        best_sad2;
  logic [BEST_IDX_W-1:0] best_idx2;
`endif

  sad_tree_acc #(.NODE_NUM(N), .PIX_WIDTH(PW), .ROWS(R)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_first(in_first),
    .in_mask(in_mask), .pix_l(pix_l), .pix_r(pix_r), .out_valid(out_valid),
    .out_ready(out_ready), .out_sad(out_sad)
`ifdef SAD_TREE_MIN_EN
    , .best_sad(best_sad), .best_idx(best_idx)
`endif
  );

  sad_tree_acc #(.NODE_NUM(N2), .PIX_WIDTH(PW), .ROWS(1)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2), .in_first(in_first2),
    .in_mask(in_mask2), .pix_l(pix_l2), .pix_r(pix_r2), .out_valid(out_valid2),
    .out_ready(1'b1), .out_sad(out_sad2)
`ifdef SAD_TREE_MIN_EN
    , .best_sad(best_sad2), .best_idx(best_idx2)
`endif
  );

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // ---------------- reference model / scoreboard ----------------
  logic [SW-1:0] exp_q[$];
  int            cyc_q[$];
  int            m_k = 0;
  int            m_acc = 0;
  int            cyc = 0;
  bit            lat_chk = 1'b0, stall_chk = 1'b0;
  logic          prev_ov = 1'b0, prev_xfer = 1'b0, prev_stall = 1'b0;
  logic [SW-1:0] held_sad = '0;
  int            last_sad = -1;
  int            first_acc2 = -1, first_out2 = -1, last_out2 = -1, n_out2 = 0;

  always @(negedge clk) begin : monitor
    int s;
    cyc++;
    if (rst) begin
      prev_ov = 1'b0; prev_xfer = 1'b0; prev_stall = 1'b0;
    end else begin
      if (in_valid && in_ready) begin
        s = 0;
        for (int i = 0; i < N; i++)
          if (in_mask[i]) s += (pix_l[i] > pix_r[i]) ? int'(pix_l[i]) - int'(pix_r[i])
                                                     : int'(pix_r[i]) - int'(pix_l[i]);
        if (in_first) begin m_k = 0; m_acc = 0; end
        m_acc += s;
        m_k++;
        if (m_k == R) begin
          exp_q.push_back(SW'(m_acc));
          cyc_q.push_back(cyc);
          m_k = 0; m_acc = 0;
        end
      end
      if (out_valid && (!prev_ov || prev_xfer)) begin
        check("result_pending", cyc_q.size() > 0, 1);
        if (cyc_q.size() > 0) begin
          s = cyc_q.pop_front();
          if (lat_chk) check("latency", cyc - s, LAT);
        end
      end
      if (prev_stall) begin
        check("valid_hold", out_valid, 1);
        check("sad_hold", out_sad, held_sad);
      end
      if (stall_chk && out_valid && !out_ready) check("in_ready_stall", in_ready, 0);
      if (out_valid && out_ready) begin
        check("xfer_pending", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) check("out_sad", out_sad, exp_q.pop_front());
        last_sad = int'(out_sad);
      end
      prev_ov    = out_valid;
      prev_xfer  = out_valid && out_ready;
      prev_stall = out_valid && !out_ready;
      held_sad   = out_sad;

      if (in_valid2 && in_ready2 && first_acc2 < 0) first_acc2 = cyc;
      if (out_valid2) begin
        check("sad2", out_sad2, 15);
        n_out2++;
        if (first_out2 < 0) first_out2 = cyc;
        last_out2 = cyc;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_row(input bit first, input logic [N-1:0] mask, input int l, input int r);
    in_first = first;
    in_mask  = mask;
    for (int i = 0; i < N; i++) begin
      pix_l[i] = l[PW-1:0];
      pix_r[i] = r[PW-1:0];
    end
  endtask

  task automatic set_rand_row(input bit first, input logic [N-1:0] mask);
    in_first = first;
    in_mask  = mask;
    for (int i = 0; i < N; i++) begin
      pix_l[i] = PW'($urandom_range(0, 255));
      pix_r[i] = PW'($urandom_range(0, 255));
    end
  endtask

  // Called right after a posedge; returns right after the posedge that took the beat.
  task automatic send();
    int n;
    bit acc;
    n = 0;
    in_valid = 1'b1;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 500);
    if (!acc) check("accept_timeout", acc, 1);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 300) check("drain_timeout", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    m_k = 0;
    m_acc = 0;
    exp_q.delete();
    cyc_q.delete();
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_sad", out_sad, 0);
    check("rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < N; i++) begin pix_l[i] = '0; pix_r[i] = '0; end
    for (int i = 0; i < N2; i++) begin pix_l2[i] = '0; pix_r2[i] = '0; end
    #1;
    do_reset();

    // uniform diff of 3 per node, 9 rows
    lat_chk = 1'b1;
    for (int r = 0; r < R; r++) begin set_row(r == 0, '1, 10, 7); send(); end
    wait_drain();
    check("blk_243", last_sad, 243);

    // largest possible block, then a single enabled node
    for (int r = 0; r < R; r++) begin set_row(r == 0, '1, 0, 255); send(); end
    wait_drain();
    check("blk_max", last_sad, 20655);
    for (int r = 0; r < R; r++) begin set_row(r == 0, 9'h010, 0, 255); send(); end
    wait_drain();
    check("blk_node4", last_sad, 2295);

    // partial block abandoned by a new first row
    for (int r = 0; r < 4; r++) begin set_rand_row(r == 0, '1); send(); end
    for (int r = 0; r < R; r++) begin set_row(r == 0, '1, 5, 4); send(); end
    wait_drain();
    check("blk_restart", last_sad, 81);
    lat_chk = 1'b0;

    // downstream stall for 10 cycles during streaming input
    stall_chk = 1'b1;
    fork
      for (int b = 0; b < 3 * R; b++) begin set_rand_row(b % R == 0, '1); send(); end
      begin
        idle(12);
        out_ready = 1'b0;
        idle(10);
        out_ready = 1'b1;
      end
    join
    wait_drain();

    // random traffic: gaps, random first, masks and backpressure
    begin
      bit done;
      done = 1'b0;
      fork
        begin
          for (int b = 0; b < 80; b++) begin
            set_rand_row($urandom_range(0, 7) == 0, N'($urandom_range(0, 511)));
            send();
            if ($urandom_range(0, 3) == 0) begin
              in_first = $urandom_range(0, 1) == 1;
              idle($urandom_range(1, 3));
            end
          end
          done = 1'b1;
        end
        while (!done) begin
          out_ready = $urandom_range(0, 2) != 0;
          idle(1);
        end
      join
      out_ready = 1'b1;
      wait_drain();
    end
    stall_chk = 1'b0;

    // reset while a result is held and the next block is partial
    out_ready = 1'b0;
    for (int r = 0; r < R + 3; r++) begin set_rand_row(r == 0, '1); send(); end
    idle(8);
    check("held_before_rst", out_valid, 1);
    do_reset();
    out_ready = 1'b1;
    for (int r = 0; r < R; r++) begin set_row(1'b0, '1, 2, 0); send(); end
    wait_drain();
    check("blk_after_rst", last_sad, 162);

`ifdef SAD_TREE_MIN_EN
    do_reset();
    begin
      int vals[4] = '{50, 30, 30, 40};
      for (int b = 0; b < 4; b++)
        for (int r = 0; r < R; r++) begin
          set_row(b == 0 && r == 0, 9'h001, (r == 0) ? vals[b] : 0, 0);
          send();
        end
    end
    wait_drain();
    check("best_sad", best_sad, 30);
    check("best_idx", best_idx, 1);
`endif

    // NODE_NUM=5, ROWS=1 streaming, d = {1,2,3,4,5}
    for (int b = 0; b < 12; b++) begin
      in_valid2 = 1'b1;
      in_first2 = $urandom_range(0, 1) == 1;
      for (int i = 0; i < N2; i++) begin
        pix_r2[i] = PW'($urandom_range(0, 200));
        pix_l2[i] = pix_r2[i] + PW'(i + 1);
        if ($urandom_range(0, 1) == 1) begin
          pix_r2[i] = pix_l2[i];
          pix_l2[i] = pix_l2[i] - PW'(i + 1);
        end
      end
      idle(1);
    end
    in_valid2 = 1'b0;
    idle(10);
    check("n_out2", n_out2, 12);
    check("latency2", first_out2 - first_acc2, LAT2);
    check("stream2", last_out2 - first_out2, 11);

    check("exp_q_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    errors++;
    $display("FAIL global_timeout: got %0d expected %0d", cyc, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
